// File: rtl/harris_frame_ctrl_pkg.sv
// Shared constants and types for the Harris corner frame controller.
package harris_frame_ctrl_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;
  localparam int WIN_RAD      = 2;
  localparam int WIN_SIZE     = 5;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_LINE,
    ACTIVE,
    LINE_GAP,
    DRAIN,
    REPORT
  } state_t;

endpackage

// File: rtl/harris_align_delay.sv
// PIPE_LAT-deep delay line carrying {shift enable, column, row} alongside the
// Harris score pipeline; flush drops in-flight windows when a frame restarts.
module harris_align_delay
  import harris_frame_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   en,
  input  coord_t col,
  input  coord_t row,
  output logic   en_d,
  output coord_t col_d,
  output coord_t row_d
);

  typedef struct packed {
    logic   en;
    coord_t col;
    coord_t row;
  } tap_t;

  tap_t taps [PIPE_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) taps[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < PIPE_LAT; i++) taps[i] <= '0;
    end else begin
      taps[0] <= '{en: en, col: col, row: row};
      for (int i = 1; i < PIPE_LAT; i++) taps[i] <= taps[i-1];
    end
  end

  assign en_d  = taps[PIPE_LAT-1].en;
  assign col_d = taps[PIPE_LAT-1].col;
  assign row_d = taps[PIPE_LAT-1].row;

endmodule

// File: rtl/harris_frame_ctrl.sv
// Frame sequencer for the 5x5 Harris datapath: pixel counters, line-buffer control,
// window alignment/border masking and a per-frame max-score corner report.
module harris_frame_ctrl
  import harris_frame_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIPE_LAT = 3,
  parameter int SCORE_W  = 16,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vga_blank,
  input  logic                      vga_vs,
  input  logic signed [SCORE_W-1:0] threshold,
  input  logic signed [SCORE_W-1:0] harris_score,
  output logic                      buf_shift_en,
  output logic                      buf_aclr,
  output logic [COORD_W-1:0]        pix_col,
  output logic [COORD_W-1:0]        pix_row,
  output logic                      win_valid,
  output logic [COORD_W-1:0]        center_x,
  output logic [COORD_W-1:0]        center_y,
  output logic                      corner_hit,
  output logic                      frame_done,
  output logic                      corner_found,
  output logic [COORD_W-1:0]        corner_x,
  output logic [COORD_W-1:0]        corner_y,
  output logic [CNT_W-1:0]          corner_count
);

  localparam coord_t H_END      = coord_t'(H_ACTIVE);
  localparam coord_t V_END      = coord_t'(V_ACTIVE);
  localparam coord_t FIRST_FULL = coord_t'(WIN_SIZE - 1);
  localparam coord_t RAD        = coord_t'(WIN_RAD);
  localparam int     DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  state_t state, state_nxt;
  logic   vs_q, blank_q, vs_fall, blank_rise;
  logic [DRAIN_W-1:0] drain_cnt;

  logic   en_d;
  coord_t col_d, row_d;

  logic signed [SCORE_W-1:0] threshold_q, hit_score, best_score;
  coord_t                    hit_x, hit_y, best_x, best_y;
  logic [CNT_W-1:0]          count;

  assign vs_fall    = vs_q & ~vga_vs;
  assign blank_rise = vga_blank & ~blank_q;

  // A vs falling edge overrides every state: the frame in progress is abandoned.
  always_comb begin
    state_nxt    = state;
    buf_shift_en = 1'b0;
    case (state)
      WAIT_VS: state_nxt = WAIT_VS;
      WAIT_LINE: begin
        if (blank_rise) begin
          buf_shift_en = 1'b1;
          state_nxt    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!vga_blank || pix_col == H_END) state_nxt = LINE_GAP;
        else buf_shift_en = 1'b1;
      end
      LINE_GAP: begin
        if (pix_row == V_END) begin
          state_nxt = DRAIN;
        end else if (blank_rise) begin
          buf_shift_en = 1'b1;
          state_nxt    = ACTIVE;
        end
      end
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = REPORT;
      REPORT:  state_nxt = WAIT_VS;
      default: state_nxt = WAIT_VS;
    endcase
    if (vs_fall) begin
      state_nxt    = WAIT_LINE;
      buf_shift_en = 1'b0;
    end
  end

  assign frame_done = (state == REPORT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_VS;
      vs_q        <= 1'b0;
      blank_q     <= 1'b0;
      buf_aclr    <= 1'b0;
      drain_cnt   <= '0;
      pix_col     <= '0;
      pix_row     <= '0;
      threshold_q <= '0;
    end else begin
      state     <= state_nxt;
      vs_q      <= vga_vs;
      blank_q   <= vga_blank;
      buf_aclr  <= vs_fall;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
      if (vs_fall) begin
        threshold_q <= threshold;
        pix_col     <= '0;
        pix_row     <= '0;
      end else if (buf_shift_en) begin
        pix_col <= pix_col + coord_t'(1);
      end else if (state == ACTIVE) begin
        // ACTIVE without a shift means the line just ended.
        pix_col <= '0;
        pix_row <= pix_row + coord_t'(1);
      end
    end
  end

  harris_align_delay #(.PIPE_LAT(PIPE_LAT)) u_align (
    .clk   (clk),
    .reset (reset),
    .flush (vs_fall),
    .en    (buf_shift_en),
    .col   (pix_col),
    .row   (pix_row),
    .en_d  (en_d),
    .col_d (col_d),
    .row_d (row_d)
  );

  assign win_valid = en_d && (col_d >= FIRST_FULL) && (row_d >= FIRST_FULL);
  assign center_x  = win_valid ? col_d - RAD : '0;
  assign center_y  = win_valid ? row_d - RAD : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corner_hit <= 1'b0;
      hit_score  <= '0;
      hit_x      <= '0;
      hit_y      <= '0;
    end else begin
      corner_hit <= ~vs_fall && win_valid && (harris_score > threshold_q);
      hit_score  <= harris_score;
      hit_x      <= center_x;
      hit_y      <= center_y;
    end
  end

  // Strict > on the best score keeps the earliest hit in raster order on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
    end else if (vs_fall) begin
      count      <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
    end else if (corner_hit) begin
      if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
      if (count == '0 || hit_score > best_score) begin
        best_score <= hit_score;
        best_x     <= hit_x;
        best_y     <= hit_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corner_found <= 1'b0;
      corner_count <= '0;
      corner_x     <= '0;
      corner_y     <= '0;
    end else if (state == DRAIN && state_nxt == REPORT) begin
      corner_found <= (count != '0);
      corner_count <= count;
      if (count != '0) begin
        corner_x <= best_x;
        corner_y <= best_y;
      end
    end
  end

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Randomized frame-level bench for harris_frame_ctrl against a score-map reference model.
module tb_harris_frame_ctrl;
  localparam int H  = 24;
  localparam int V  = 20;
  localparam int P  = 3;
  localparam int SW = 16;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 vga_blank, vga_vs;
  logic signed [SW-1:0] threshold, harris_score;
  logic                 buf_shift_en, buf_aclr, win_valid, corner_hit, frame_done, corner_found;
  logic [9:0]           pix_col, pix_row, center_x, center_y, corner_x, corner_y;
  logic [CW-1:0]        corner_count;

  always #5 clk = ~clk;

  harris_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .PIPE_LAT(P), .SCORE_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .vga_blank(vga_blank), .vga_vs(vga_vs),
    .threshold(threshold), .harris_score(harris_score),
    .buf_shift_en(buf_shift_en), .buf_aclr(buf_aclr), .pix_col(pix_col), .pix_row(pix_row),
    .win_valid(win_valid), .center_x(center_x), .center_y(center_y), .corner_hit(corner_hit),
    .frame_done(frame_done), .corner_found(corner_found), .corner_x(corner_x),
    .corner_y(corner_y), .corner_count(corner_count)
  );

  int checks = 0, errors = 0;
  int cmap [V][H];          // score of the window centred at [y][x]
  int sq [$];               // scores in flight towards the datapath output
  int rep_x = 0, rep_y = 0, exp_cnt = 0, exp_hits = 0;
  int ehx [$], ehy [$];

  // Monitor: observed activity, with raster-order check of every valid window centre.
  int shift_cnt = 0, valid_cnt = 0, aclr_cnt = 0, done_cnt = 0, center_err = 0;
  int hx_q [$], hy_q [$];
  int ex_x = 2, ex_y = 2, pv_x = 0, pv_y = 0;
  logic pv_wv = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (buf_shift_en) shift_cnt++;
      if (frame_done) done_cnt++;
      if (buf_aclr) begin
        aclr_cnt++;
        ex_x = 2;
        ex_y = 2;
      end
      if (corner_hit) begin
        hx_q.push_back(pv_x);
        hy_q.push_back(pv_y);
        if (!pv_wv) center_err++;
      end
      if (win_valid) begin
        valid_cnt++;
        if (int'(center_x) != ex_x || int'(center_y) != ex_y) center_err++;
        if (ex_x == H - 3) begin
          ex_x = 2;
          ex_y++;
        end else ex_x++;
      end
      pv_x  = int'(center_x);
      pv_y  = int'(center_y);
      pv_wv = win_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic int junk();
    return int'($urandom_range(1000, 9000));
  endfunction

  task automatic step(input logic blank, input logic vs, input int sc);
    vga_blank = blank;
    vga_vs    = vs;
    sq.push_back(sc);
    harris_score = SW'(sq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) cmap[y][x] = v;
  endtask

  // Reference: every interior centre in raster order, strict compare, first max wins.
  task automatic model_frame(input int thr);
    int n, bs, bx, by;
    n = 0; bs = 0; bx = 0; by = 0;
    ehx.delete();
    ehy.delete();
    for (int y = 2; y <= V - 3; y++)
      for (int x = 2; x <= H - 3; x++)
        if (cmap[y][x] > thr) begin
          ehx.push_back(x);
          ehy.push_back(y);
          if (n == 0 || cmap[y][x] > bs) begin
            bs = cmap[y][x]; bx = x; by = y;
          end
          n++;
        end
    exp_hits = n;
    exp_cnt  = (n > 255) ? 255 : n;
    if (n != 0) begin
      rep_x = bx;
      rep_y = by;
    end
  endtask

  task automatic drive_frame(input int thr, input int abort_row);
    int sc;
    repeat (3) step(1'b0, 1'b1, junk());
    threshold = SW'(thr);
    step(1'b0, 1'b0, junk());
    threshold = SW'($urandom);
    step(1'b0, 1'b0, junk());
    for (int r = 0; r < V; r++) begin
      repeat ($urandom_range(2, 5)) step(1'b0, 1'b1, junk());
      for (int c = 0; c < H; c++) begin
        if (r == abort_row && c == H / 2) begin
          step(1'b1, 1'b0, junk());
          step(1'b0, 1'b0, junk());
          step(1'b0, 1'b1, junk());
          return;
        end
        sc = (c >= 4 && r >= 4) ? cmap[r-2][c-2] : junk();
        step(1'b1, 1'b1, sc);
      end
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b1, junk());
    end
    repeat (P + 8) step(1'b0, 1'b1, junk());
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({buf_shift_en, buf_aclr, win_valid, corner_hit, frame_done, corner_found} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {buf_shift_en, buf_aclr, win_valid, corner_hit, frame_done, corner_found});
    end
    checks++;
    if ({pix_col, pix_row, center_x, center_y} !== 40'b0) begin
      errors++;
      $display("FAIL reset_coords: col %0d row %0d cx %0d cy %0d, required all 0",
               pix_col, pix_row, center_x, center_y);
    end
    checks++;
    if ({corner_x, corner_y, corner_count} !== 28'b0) begin
      errors++;
      $display("FAIL reset_report: x %0d y %0d count %0d, required all 0", corner_x, corner_y, corner_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_blank_frame();
    int s0, v0, d0, a0, e0;
    s0 = shift_cnt; v0 = valid_cnt; d0 = done_cnt; a0 = aclr_cnt; e0 = center_err;
    fill(0);
    drive_frame(100, -1);
    model_frame(100);
    checks++;
    if (shift_cnt - s0 != H * V) begin
      errors++; $display("FAIL blank_shift: got %0d shift cycles, required %0d", shift_cnt - s0, H * V);
    end
    checks++;
    if (valid_cnt - v0 != (H - 4) * (V - 4)) begin
      errors++; $display("FAIL blank_valid: got %0d windows, required %0d", valid_cnt - v0, (H - 4) * (V - 4));
    end
    checks++;
    if (center_err != e0) begin
      errors++; $display("FAIL blank_centres: %0d misplaced centres, required 0", center_err - e0);
    end
    checks++;
    if (done_cnt - d0 != 1 || aclr_cnt - a0 != 1) begin
      errors++; $display("FAIL blank_pulses: done %0d aclr %0d, required 1 and 1", done_cnt - d0, aclr_cnt - a0);
    end
    checks++;
    if (corner_found !== 1'b0 || int'(corner_count) != exp_cnt) begin
      errors++; $display("FAIL blank_report: found %b count %0d, required 0 and %0d", corner_found, corner_count, exp_cnt);
    end
  endtask

  task automatic test_single();
    int h0;
    h0 = hx_q.size();
    fill(0);
    cmap[V/2][H/2] = 500;
    drive_frame(100, -1);
    model_frame(100);
    checks++;
    if (hx_q.size() - h0 != 1 || hx_q[h0] != H / 2 || hy_q[h0] != V / 2) begin
      errors++; $display("FAIL single_hit: %0d hits, first at (%0d,%0d), required 1 at (%0d,%0d)",
                         hx_q.size() - h0, hx_q[h0], hy_q[h0], H / 2, V / 2);
    end
    checks++;
    if (int'(corner_x) != rep_x || int'(corner_y) != rep_y || int'(corner_count) != exp_cnt || !corner_found) begin
      errors++; $display("FAIL single_report: (%0d,%0d) count %0d found %b, required (%0d,%0d) count %0d found 1",
                         corner_x, corner_y, corner_count, corner_found, rep_x, rep_y, exp_cnt);
    end
  endtask

  task automatic test_tie();
    int h0;
    h0 = hx_q.size();
    fill(0);
    cmap[2][2] = 300;
    cmap[V-3][H-3] = 300;
    cmap[6][6] = 200;
    drive_frame(100, -1);
    model_frame(100);
    checks++;
    if (hx_q.size() - h0 != exp_hits) begin
      errors++; $display("FAIL tie_hits: got %0d hits, required %0d", hx_q.size() - h0, exp_hits);
    end
    checks++;
    if (int'(corner_x) != rep_x || int'(corner_y) != rep_y || int'(corner_count) != exp_cnt) begin
      errors++; $display("FAIL tie_report: (%0d,%0d) count %0d, required (%0d,%0d) count %0d",
                         corner_x, corner_y, corner_count, rep_x, rep_y, exp_cnt);
    end
  endtask

  task automatic test_random();
    int h0, thr;
    logic bad;
    for (int f = 0; f < 3; f++) begin
      h0 = hx_q.size();
      thr = int'($urandom_range(0, 1500)) - 500;
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++) cmap[y][x] = (int'($urandom_range(0, 30)) - 15) * 100;
      drive_frame(thr, -1);
      model_frame(thr);
      bad = (hx_q.size() - h0 != ehx.size());
      if (!bad)
        foreach (ehx[i]) if (hx_q[h0+i] != ehx[i] || hy_q[h0+i] != ehy[i]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++; $display("FAIL random_hits[%0d]: got %0d hits, required %0d in raster order",
                           f, hx_q.size() - h0, ehx.size());
      end
      checks++;
      if (int'(corner_x) != rep_x || int'(corner_y) != rep_y || int'(corner_count) != exp_cnt ||
          corner_found !== (exp_cnt != 0)) begin
        errors++; $display("FAIL random_report[%0d]: (%0d,%0d) count %0d found %b, required (%0d,%0d) count %0d",
                           f, corner_x, corner_y, corner_count, corner_found, rep_x, rep_y, exp_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    int h0;
    h0 = hx_q.size();
    fill(1000);
    drive_frame(0, -1);
    model_frame(0);
    checks++;
    if (hx_q.size() - h0 != exp_hits) begin
      errors++; $display("FAIL sat_hits: got %0d hits, required %0d", hx_q.size() - h0, exp_hits);
    end
    checks++;
    if (int'(corner_count) != 255 || int'(corner_x) != 2 || int'(corner_y) != 2) begin
      errors++; $display("FAIL sat_report: count %0d at (%0d,%0d), required 255 at (2,2)",
                         corner_count, corner_x, corner_y);
    end
  endtask

  task automatic test_abort();
    int d0, a0;
    d0 = done_cnt; a0 = aclr_cnt;
    fill(0);
    cmap[5][5] = 5000;
    drive_frame(0, V / 2);
    checks++;
    if (done_cnt != d0 || aclr_cnt - a0 != 2) begin
      errors++; $display("FAIL abort_pulses: done %0d aclr %0d, required 0 and 2", done_cnt - d0, aclr_cnt - a0);
    end
    checks++;
    if (int'(corner_x) != rep_x || int'(corner_y) != rep_y || int'(corner_count) != exp_cnt) begin
      errors++; $display("FAIL abort_held: (%0d,%0d) count %0d, required (%0d,%0d) count %0d",
                         corner_x, corner_y, corner_count, rep_x, rep_y, exp_cnt);
    end
    d0 = done_cnt;
    drive_frame(0, -1);
    model_frame(0);
    checks++;
    if (done_cnt - d0 != 1 || int'(corner_x) != rep_x || int'(corner_y) != rep_y || int'(corner_count) != exp_cnt) begin
      errors++; $display("FAIL abort_next: done %0d (%0d,%0d) count %0d, required 1 (%0d,%0d) count %0d",
                         done_cnt - d0, corner_x, corner_y, corner_count, rep_x, rep_y, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int s0, d0;
    repeat (3) step(1'b0, 1'b1, junk());
    threshold = SW'(0);
    step(1'b0, 1'b0, junk());
    step(1'b0, 1'b1, junk());
    repeat (3) step(1'b0, 1'b1, junk());
    repeat (H / 2) step(1'b1, 1'b1, junk());
    #3 reset = 1'b1;
    #2;
    checks++;
    if ({buf_shift_en, buf_aclr, win_valid, corner_hit, frame_done, corner_found} !== 6'b0 ||
        {pix_col, pix_row, center_x, center_y, corner_x, corner_y, corner_count} !== 68'b0) begin
      errors++; $display("FAIL midreset_zero: shift %b col %0d row %0d x %0d y %0d count %0d, required all 0",
                         buf_shift_en, pix_col, pix_row, corner_x, corner_y, corner_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rep_x = 0; rep_y = 0; exp_cnt = 0;
    s0 = shift_cnt;
    repeat (H) step(1'b1, 1'b1, junk());
    repeat (3) step(1'b0, 1'b1, junk());
    repeat (H) step(1'b1, 1'b1, junk());
    checks++;
    if (shift_cnt != s0) begin
      errors++; $display("FAIL midreset_noshift: got %0d shifts before vs edge, required 0", shift_cnt - s0);
    end
    d0 = done_cnt;
    fill(0);
    cmap[V-3][H-3] = 999;
    drive_frame(500, -1);
    model_frame(500);
    checks++;
    if (done_cnt - d0 != 1 || int'(corner_x) != rep_x || int'(corner_y) != rep_y || int'(corner_count) != exp_cnt) begin
      errors++; $display("FAIL midreset_frame: done %0d (%0d,%0d) count %0d, required 1 (%0d,%0d) count %0d",
                         done_cnt - d0, corner_x, corner_y, corner_count, rep_x, rep_y, exp_cnt);
    end
  endtask

  initial begin
    reset        = 1'b1;
    vga_blank    = 1'b0;
    vga_vs       = 1'b1;
    threshold    = '0;
    harris_score = '0;
    for (int i = 0; i < P; i++) sq.push_back(junk());
    test_reset();
    test_blank_frame();
    test_single();
    test_tie();
    test_random();
    test_saturate();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
